alu_seq_unit: RTL and testbench

//  Parametrised, multi-cycle integer ALU for the RV32I core's execute stage.

---
 rtl/alu_seq_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_seq_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Multi-cycle RV32I execute-stage ALU (ALU-imm, ALU-reg, branch compare); ALU_BARREL_SHIFT_EN selects a one-cycle barrel shifter.
// Latency 1 for non-shift ops; iterative shifts take 1 + ceil(shamt/SHIFT_STEP) cycles.
// One op in flight: in_ready only in IDLE, result held in DONE until out_ready; flush aborts.
module alu_seq_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            isALUimm,
    input  logic            isALUreg,
    input  logic            isBranch,
    input  logic [7:0]      funct3oh,
    input  logic [3:0]      funct3b,
    input  logic            br_unsigned,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [XLEN-1:0]   shreg;
    logic [SHW-1:0]    cnt;
    logic              sh_left;
    logic              sh_arith;

    logic              type_ok;
    logic              alu_ok;
    logic              br_ok;
    logic              is_sub;
    logic [SHW-1:0]    shamt;
    logic              go_shift;
    logic [XLEN-1:0]   sll_res;
    logic [XLEN-1:0]   sr_res;
    logic [XLEN-1:0]   alu_res;
    logic              slt_bit;
    logic              sltu_bit;
    logic              br_eq;
    logic              br_lt;
    logic              br_res;
    logic [SHW-1:0]    step;
    logic [XLEN-1:0]   sh_sll;
    logic [XLEN-1:0]   sh_srl;
    logic [XLEN-1:0]   sh_sra;
    logic [XLEN-1:0]   sh_next;
    logic              unused_f7;

    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    assign in_ready = (state == IDLE);

    // Illegal encodings fall out of these qualifiers and yield result=0, br_taken=0.
    assign type_ok = $onehot({isALUimm, isALUreg, isBranch});
    assign alu_ok  = type_ok & (isALUimm | isALUreg) & $onehot(funct3oh);
    assign br_ok   = type_ok & isBranch & $onehot(funct3b);
    assign is_sub  = isALUreg & funct7[5];
    assign shamt   = rs2[SHW-1:0];

    assign slt_bit  = $signed(rs1) < $signed(rs2);
    assign sltu_bit = rs1 < rs2;

`ifdef ALU_BARREL_SHIFT_EN
    logic [XLEN-1:0] bs_srl;
    logic [XLEN-1:0] bs_sra;
    assign bs_srl   = rs1 >> shamt;
    assign bs_sra   = $signed(rs1) >>> shamt;
    assign sll_res  = rs1 << shamt;
    assign sr_res   = funct7[5] ? bs_sra : bs_srl;
    assign go_shift = 1'b0;
`else
    // Only reached with shamt==0 here; nonzero shamts go through SHIFT.
    assign sll_res  = rs1;
    assign sr_res   = rs1;
    assign go_shift = alu_ok & (funct3oh[1] | funct3oh[5]) & (shamt != '0);
`endif

    always_comb begin
        alu_res = '0;
        if (alu_ok) begin
            if (funct3oh[0]) alu_res = is_sub ? rs1 - rs2 : rs1 + rs2;
            if (funct3oh[1]) alu_res = sll_res;
            if (funct3oh[2]) alu_res = {{(XLEN-1){1'b0}}, slt_bit};
            if (funct3oh[3]) alu_res = {{(XLEN-1){1'b0}}, sltu_bit};
            if (funct3oh[4]) alu_res = rs1 ^ rs2;
            if (funct3oh[5]) alu_res = sr_res;
            if (funct3oh[6]) alu_res = rs1 | rs2;
            if (funct3oh[7]) alu_res = rs1 & rs2;
        end
    end

    assign br_eq  = (rs1 == rs2);
    assign br_lt  = br_unsigned ? sltu_bit : slt_bit;
    assign br_res = br_ok & |(funct3b & {~br_lt, br_lt, ~br_eq, br_eq});

    // Last step may be shorter than SHIFT_STEP when shamt is not a multiple of it.
    assign step    = (cnt < SHW'(SHIFT_STEP)) ? cnt : SHW'(SHIFT_STEP);
    assign sh_sll  = shreg << step;
    assign sh_srl  = shreg >> step;
    assign sh_sra  = $signed(shreg) >>> step;
    assign sh_next = sh_left ? sh_sll : (sh_arith ? sh_sra : sh_srl);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            br_taken  <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            sh_left   <= 1'b0;
            sh_arith  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (go_shift) begin
                            state    <= SHIFT;
                            shreg    <= rs1;
                            cnt      <= shamt;
                            sh_left  <= funct3oh[1];
                            sh_arith <= funct7[5];
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            br_taken  <= br_res;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= sh_next;
                    cnt   <= cnt - step;
                    if (cnt == step) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= sh_next;
                        br_taken  <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit (XLEN=32, SHIFT_STEP=1).
module tb_alu_seq_unit;

`ifdef ALU_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        isALUimm = 1'b0;
    logic        isALUreg = 1'b0;
    logic        isBranch = 1'b0;
    logic [7:0]  funct3oh = '0;
    logic [3:0]  funct3b = '0;
    logic        br_unsigned = 1'b0;
    logic [6:0]  funct7 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        br_taken;

    always #5 clk = ~clk;

    alu_seq_unit #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .isALUimm(isALUimm), .isALUreg(isALUreg), .isBranch(isBranch),
        .funct3oh(funct3oh), .funct3b(funct3b), .br_unsigned(br_unsigned),
        .funct7(funct7), .rs1(rs1), .rs2(rs2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .br_taken(br_taken)
    );

    typedef struct {
        logic        imm;
        logic        rg;
        logic        br;
        logic [7:0]  f3oh;
        logic [3:0]  f3b;
        logic        bru;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        tk;
        int          lat;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        isALUimm    = v.imm;
        isALUreg    = v.rg;
        isBranch    = v.br;
        funct3oh    = v.f3oh;
        funct3b     = v.f3b;
        br_unsigned = v.bru;
        funct7      = v.f7;
        rs1         = v.a;
        rs2         = v.b;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        int   exp_lat;
        bit   seen;
        v = tv[i];
        exp_lat = BARREL ? 1 : v.lat;
        @(negedge clk);
        check($sformatf("v%0d in_ready_pre", i), 32'(in_ready), 32'd1);
        apply(v);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check($sformatf("v%0d latency", i), 32'(lat), 32'(exp_lat));
        check($sformatf("v%0d result", i), result, v.res);
        check($sformatf("v%0d br_taken", i), 32'(br_taken), 32'(v.tk));
        @(negedge clk);
        check($sformatf("v%0d in_ready_post", i), 32'(in_ready), 32'd1);
        check($sformatf("v%0d out_valid_post", i), 32'(out_valid), 32'd0);
    endtask

    initial begin
        //        imm  rg   br   f3oh   f3b   bru  f7     a             b             res           tk   lat
        tv[0]  = '{1'b0,1'b1,1'b0,8'h01,4'h0,1'b0,7'h00,32'd5,        32'd7,        32'd12,       1'b0,1};  // ADD
        tv[1]  = '{1'b0,1'b1,1'b0,8'h01,4'h0,1'b0,7'h20,32'd3,        32'd5,        32'hFFFFFFFE, 1'b0,1};  // SUB
        tv[2]  = '{1'b1,1'b0,1'b0,8'h01,4'h0,1'b0,7'h20,32'd1,        32'hFFFFFFFF, 32'h0,        1'b0,1};  // ADDI, f7[5] ignored
        tv[3]  = '{1'b1,1'b0,1'b0,8'h20,4'h0,1'b0,7'h20,32'h80000000, 32'd4,        32'hF8000000, 1'b0,5};  // SRAI 4
        tv[4]  = '{1'b1,1'b0,1'b0,8'h20,4'h0,1'b0,7'h00,32'h80000000, 32'd4,        32'h08000000, 1'b0,5};  // SRLI 4
        tv[5]  = '{1'b1,1'b0,1'b0,8'h02,4'h0,1'b0,7'h00,32'h00001234, 32'd0,        32'h00001234, 1'b0,1};  // SLLI 0
        tv[6]  = '{1'b0,1'b1,1'b0,8'h02,4'h0,1'b0,7'h00,32'd1,        32'd31,       32'h80000000, 1'b0,32}; // SLL 31
        tv[7]  = '{1'b0,1'b1,1'b0,8'h04,4'h0,1'b0,7'h00,32'hFFFFFFFF, 32'd1,        32'd1,        1'b0,1};  // SLT
        tv[8]  = '{1'b0,1'b1,1'b0,8'h08,4'h0,1'b0,7'h00,32'hFFFFFFFF, 32'd1,        32'd0,        1'b0,1};  // SLTU
        tv[9]  = '{1'b1,1'b0,1'b0,8'h10,4'h0,1'b0,7'h00,32'h000000F0, 32'h000000FF, 32'h0000000F, 1'b0,1};  // XORI
        tv[10] = '{1'b0,1'b1,1'b0,8'h40,4'h0,1'b0,7'h00,32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0,1};  // OR
        tv[11] = '{1'b1,1'b0,1'b0,8'h80,4'h0,1'b0,7'h00,32'h000000F0, 32'h0000003C, 32'h00000030, 1'b0,1};  // ANDI
        tv[12] = '{1'b0,1'b0,1'b1,8'h00,4'h4,1'b0,7'h00,32'hFFFFFFFF, 32'd1,        32'd0,        1'b1,1};  // BLT
        tv[13] = '{1'b0,1'b0,1'b1,8'h00,4'h4,1'b1,7'h00,32'hFFFFFFFF, 32'd1,        32'd0,        1'b0,1};  // BLTU
        tv[14] = '{1'b0,1'b0,1'b1,8'h00,4'h1,1'b0,7'h00,32'd7,        32'd7,        32'd0,        1'b1,1};  // BEQ
        tv[15] = '{1'b0,1'b0,1'b1,8'h00,4'h2,1'b0,7'h00,32'd7,        32'd7,        32'd0,        1'b0,1};  // BNE
        tv[16] = '{1'b0,1'b0,1'b1,8'h00,4'h8,1'b0,7'h00,32'd5,        32'hFFFFFFFD, 32'd0,        1'b1,1};  // BGE 5 >= -3
        tv[17] = '{1'b0,1'b1,1'b0,8'h20,4'h0,1'b0,7'h20,32'hF0000000, 32'h00000024, 32'hFF000000, 1'b0,5};  // SRA, shamt masked to 4
        tv[18] = '{1'b1,1'b1,1'b0,8'h01,4'h0,1'b0,7'h00,32'd5,        32'd7,        32'd0,        1'b0,1};  // two op types
        tv[19] = '{1'b1,1'b0,1'b0,8'h22,4'h0,1'b0,7'h00,32'd1,        32'd4,        32'd0,        1'b0,1};  // f3oh not one-hot
        tv[20] = '{1'b0,1'b0,1'b1,8'h00,4'h0,1'b0,7'h00,32'd7,        32'd7,        32'd0,        1'b0,1};  // f3b zero
        tv[21] = '{1'b0,1'b0,1'b0,8'h01,4'h0,1'b0,7'h00,32'd5,        32'd7,        32'd0,        1'b0,1};  // no op type
        tv[22] = '{1'b0,1'b0,1'b1,8'h00,4'h8,1'b1,7'h00,32'd1,        32'hFFFFFFFF, 32'd0,        1'b0,1};  // BGEU

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset result", result, 32'd0);
        check("reset br_taken", 32'(br_taken), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Backpressure: result must hold and a competing op must not be accepted.
        @(negedge clk);
        out_ready = 1'b0;
        apply(tv[9]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d result", k), result, 32'h0000000F);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            if (k == 0) begin
                apply(tv[0]);
                in_valid = 1'b1;
            end
            @(negedge clk);
        end
        check("bp3 result", result, 32'h0000000F);
        check("bp3 out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp retire out_valid", 32'(out_valid), 32'd0);
        check("bp retire in_ready", 32'(in_ready), 32'd1);

        // Flush during SLL by 31, with an op offered in the flush cycle.
        out_ready = 1'b0;
        apply(tv[6]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        apply(tv[0]);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush in_ready", 32'(in_ready), 32'd1);
        check("flush out_valid", 32'(out_valid), 32'd0);
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("flush no spurious out_valid", 32'(seen), 32'd0);
        end
        out_ready = 1'b1;
        run_vec(1);

        // Reset during SLL by 31 after a nonzero result.
        run_vec(0);
        out_ready = 1'b0;
        apply(tv[6]);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst result", result, 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst br_taken", 32'(br_taken), 32'd0);
        begin
            bit seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("rst no spurious out_valid", 32'(seen), 32'd0);
        end
        out_ready = 1'b1;
        run_vec(14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
